// File: rtl/tile_spawn_controller.sv
// Spawn controller: builds the empty-cell mask for the random tile generator,
// waits for a hit (or falls back to a lowest-index scan) and writes one new tile.
module tile_spawn_controller #(
  parameter int         MAX_TRIES = 32,
  parameter logic [3:0] EXP_TWO   = 4'd1,
  parameter logic [3:0] EXP_FOUR  = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_req,
  input  logic [63:0] board,
  output logic [15:0] empty_mask,
  input  logic        gen_done,
  input  logic [3:0]  gen_pos,
  input  logic        gen_preset,
  output logic        board_we,
  output logic [3:0]  board_addr,
  output logic [3:0]  board_data,
  output logic        spawn_ack,
  output logic        board_full,
  output logic        fallback_used
);

  typedef enum logic [2:0] {IDLE, MASK, SETTLE, WAIT, SCAN, WRITE, ACK} state_t;

  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  state_t      state;
  logic [7:0]  tries;
  logic [15:0] board_empty;
  logic [3:0]  scan_idx;

  always_comb begin
    board_empty = '0;
    for (int i = 0; i < 16; i++) begin
      board_empty[i] = (board[4*i +: 4] == 4'd0);
    end
  end

  // Walk from the top down so the lowest set bit is the last one to win.
  always_comb begin
    scan_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (empty_mask[i]) scan_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tries         <= '0;
      empty_mask    <= '0;
      board_we      <= 1'b0;
      board_addr    <= '0;
      board_data    <= '0;
      spawn_ack     <= 1'b0;
      board_full    <= 1'b0;
      fallback_used <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spawn_ack <= 1'b0;
          if (spawn_req) state <= MASK;
        end
        MASK: begin
          empty_mask    <= board_empty;
          fallback_used <= 1'b0;
          if (board_empty == 16'd0) begin
            board_full <= 1'b1;
            spawn_ack  <= 1'b1;
            state      <= ACK;
          end else begin
            board_full <= 1'b0;
            state      <= SETTLE;
          end
        end
        // The generator's gen_done still reflects the previous mask here.
        SETTLE: begin
          tries <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (gen_done) begin
            board_addr <= gen_pos;
            board_data <= gen_preset ? EXP_FOUR : EXP_TWO;
            board_we   <= 1'b1;
            state      <= WRITE;
          end else begin
            tries <= tries + 8'd1;
            if (tries == LAST_TRY) state <= SCAN;
          end
        end
        SCAN: begin
          board_addr    <= scan_idx;
          board_data    <= EXP_TWO;
          fallback_used <= 1'b1;
          board_we      <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          board_we  <= 1'b0;
          spawn_ack <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          spawn_ack <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawn_controller.sv
// Self-checking bench for tile_spawn_controller: table of spawn scenarios with a
// scoreboard of expected write/ack results, plus a mid-operation reset sequence.
module tb_tile_spawn_controller;

  localparam int MAX_TRIES = 4;
  localparam int BUDGET    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spawn_req = 1'b0;
  logic [63:0] board = '0;
  logic [15:0] empty_mask;
  logic        gen_done = 1'b0;
  logic [3:0]  gen_pos = '0;
  logic        gen_preset = 1'b0;
  logic        board_we;
  logic [3:0]  board_addr;
  logic [3:0]  board_data;
  logic        spawn_ack;
  logic        board_full;
  logic        fallback_used;

  int vectors = 0;
  int miscompares = 0;

  tile_spawn_controller #(.MAX_TRIES(MAX_TRIES), .EXP_TWO(4'd1), .EXP_FOUR(4'd2)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .board(board),
    .empty_mask(empty_mask), .gen_done(gen_done), .gen_pos(gen_pos),
    .gen_preset(gen_preset), .board_we(board_we), .board_addr(board_addr),
    .board_data(board_data), .spawn_ack(spawn_ack), .board_full(board_full),
    .fallback_used(fallback_used)
  );

  always #5 clk = ~clk;

  // hitWait: WAIT cycle (1-based) on which gen_done is raised, 0 = never.
  typedef struct {
    logic [63:0] board;
    int          hitWait;
    logic [3:0]  pos;
    logic        preset;
    logic        settlePulse;
    logic        full;
    logic        fb;
    logic [3:0]  addr;
    logic [3:0]  data;
    int          weAt;
    int          ackAt;
  } vec_t;

  typedef struct {
    logic [15:0] mask;
    logic        full;
    logic        fb;
    logic [3:0]  addr;
    logic [3:0]  data;
    int          weAt;
    int          ackAt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  int          obsWeCount, obsWeAt, obsAckAt;
  logic [3:0]  obsAddr, obsData;
  logic        obsFull, obsFb, obsAckLow;
  logic [15:0] obsMask;

  function automatic logic [15:0] emptyOf(input logic [63:0] b);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = (b[4*i +: 4] == 4'd0);
    return m;
  endfunction

  function automatic vec_t mkVec(input logic [63:0] b, input int hit, input logic [3:0] pos,
                                 input logic preset, input logic settle, input logic full,
                                 input logic fb, input logic [3:0] addr, input logic [3:0] data,
                                 input int weAt, input int ackAt);
    vec_t v;
    v.board = b; v.hitWait = hit; v.pos = pos; v.preset = preset; v.settlePulse = settle;
    v.full = full; v.fb = fb; v.addr = addr; v.data = data; v.weAt = weAt; v.ackAt = ackAt;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Drives one request and records what the DUT does, one sample per falling edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.mask = emptyOf(v.board); e.full = v.full; e.fb = v.fb;
    e.addr = v.addr; e.data = v.data; e.weAt = v.weAt; e.ackAt = v.ackAt;
    sb.push_back(e);
    obsWeCount = 0; obsWeAt = -1; obsAckAt = -1; obsAckLow = 1'b0;
    obsAddr = '0; obsData = '0; obsFull = 1'b0; obsFb = 1'b0; obsMask = '0;
    @(negedge clk);
    board = v.board; spawn_req = 1'b1; gen_done = 1'b0;
    for (int j = 1; j <= BUDGET; j++) begin
      @(negedge clk);
      if (j == 1) spawn_req = 1'b0;
      if (board_we) begin
        obsWeCount++; obsWeAt = j; obsAddr = board_addr; obsData = board_data;
      end
      if (obsAckAt >= 0 && j == obsAckAt + 1) begin
        obsAckLow = !spawn_ack;
        break;
      end
      if (spawn_ack && obsAckAt < 0) begin
        obsAckAt = j; obsFull = board_full; obsFb = fallback_used; obsMask = empty_mask;
      end
      gen_done   = (v.hitWait != 0 && j == 2 + v.hitWait) || (v.settlePulse && j == 2);
      gen_pos    = v.pos;
      gen_preset = v.preset;
    end
    gen_done = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compare({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    compare({tag, "_ack_at"}, obsAckAt, e.ackAt);
    compare({tag, "_ack_one_cycle"}, obsAckLow, 1);
    compare({tag, "_mask"}, obsMask, e.mask);
    compare({tag, "_full"}, obsFull, e.full);
    compare({tag, "_fallback"}, obsFb, e.fb);
    compare({tag, "_we_count"}, obsWeCount, e.full ? 0 : 1);
    if (!e.full) begin
      compare({tag, "_we_at"}, obsWeAt, e.weAt);
      compare({tag, "_addr"}, obsAddr, e.addr);
      compare({tag, "_data"}, obsData, e.data);
    end
  endtask

  task automatic checkAllZero(input string tag);
    compare({tag, "_empty_mask"}, empty_mask, 0);
    compare({tag, "_board_we"}, board_we, 0);
    compare({tag, "_board_addr"}, board_addr, 0);
    compare({tag, "_board_data"}, board_data, 0);
    compare({tag, "_spawn_ack"}, spawn_ack, 0);
    compare({tag, "_board_full"}, board_full, 0);
    compare({tag, "_fallback_used"}, fallback_used, 0);
  endtask

  initial begin
    int strayWe, strayAck;

    vecs[0] = mkVec(64'h0000_0000_0000_0000, 1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  4'd1, 4, 5);
    vecs[1] = mkVec(64'h1111_1111_1111_1111, 1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0, -1, 2);
    vecs[2] = mkVec(64'h1111_1101_1111_1111, 0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  4'd1, 8, 9);
    vecs[3] = mkVec(64'h1110_1111_1111_0111, 2, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd2, 5, 6);
    vecs[4] = mkVec(64'h0000_3021_0000_5400, 4, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  4'd1, 7, 8);
    vecs[5] = mkVec(64'h0000_0000_00A0_1234, 0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  4'd1, 8, 9);
    vecs[6] = mkVec(64'h1234_0000_5678_9ABC, 1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  4'd2, 4, 5);

    #3 rst = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset pulse while the controller sits in WAIT with no generator hit.
    @(negedge clk);
    board = '0; spawn_req = 1'b1; gen_done = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) spawn_req = 1'b0;
    end
    compare("pre_reset_mask", empty_mask, 16'hFFFF);
    #2 rst = 1'b0;
    #1 checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b1;
    strayWe = 0; strayAck = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (board_we) strayWe++;
      if (spawn_ack) strayAck++;
    end
    compare("midreset_no_we", strayWe, 0);
    compare("midreset_no_ack", strayAck, 0);

    applyStimulus(vecs[0]);
    checkOutput("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
